// File: rtl/instr_aligner_if.sv
// instr_aligner_if: fetch-side, redirect and decode-side signals of the instruction aligner.
//   fetch_*     : word stream from the fetcher and the next word address requested from it
//   redirect*   : flush and restart at a new PC
//   instr_*     : aligned instruction stream towards the decoder
//   count       : halfwords currently buffered
// Modport master is the aligner's view; modport slave is the fetcher/decoder/environment view.
interface instr_aligner_if #(
  parameter int DEPTH_HW = 8
) ();
  localparam int CNT_W = $clog2(DEPTH_HW) + 1;

  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      fetch_word;
  logic [31:0]      fetch_addr;
  logic [31:0]      fetch_req_pc;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic             instr_compressed;
  logic             instr_illegal;
  logic [CNT_W-1:0] count;

  modport master (
    input  fetch_valid, fetch_word, fetch_addr, redirect, redirect_pc, instr_ready,
    output fetch_ready, fetch_req_pc, instr_valid, instr, instr_pc,
           instr_compressed, instr_illegal, count
  );

  modport slave (
    output fetch_valid, fetch_word, fetch_addr, redirect, redirect_pc, instr_ready,
    input  fetch_ready, fetch_req_pc, instr_valid, instr, instr_pc,
           instr_compressed, instr_illegal, count
  );
endinterface

// File: rtl/instr_aligner.sv
// instr_aligner: turns 32-bit fetch words into aligned RV32 instructions (16- or 32-bit)
// with their PC. Owns PC sequencing and the fetch request address.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : instr_aligner_if.master (fetch in, redirect in, instruction out, count out)
// Words are split into halfwords and kept in a circular buffer; the head halfword's
// low two bits decide whether one or two halfwords form the next instruction.
module instr_aligner #(
  parameter int          DEPTH_HW = 8,
  parameter bit          ENABLE_C = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic            clk,
  input logic            reset,
  instr_aligner_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH_HW);
  localparam int CNT_W = PTR_W + 1;
  // Accept a word only while two free slots remain, so a push never overflows.
  localparam logic [CNT_W-1:0] CNT_ROOM = CNT_W'(DEPTH_HW - 2);

  logic [15:0]      slot_q [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             skip_low_q, skip_low_d;

  logic [15:0]      head_hw, next_hw;
  logic             head_is32, have_instr;
  logic             accept, push, pop;
  logic [CNT_W-1:0] push_n, pop_n;

  always_comb begin
    head_hw    = slot_q[rd_ptr_q];
    next_hw    = slot_q[rd_ptr_q + PTR_W'(1)];
    head_is32  = (head_hw[1:0] == 2'b11);
    have_instr = head_is32 ? (count_q >= CNT_W'(2)) : (count_q >= CNT_W'(1));
    accept     = bus.fetch_valid && bus.fetch_ready;
    // A word whose address differs from the requested one is an in-flight stale
    // fetch: it is consumed (accepted) but never written.
    push       = accept && !bus.redirect && (bus.fetch_addr == req_pc_q);
    pop        = have_instr && bus.instr_ready && !bus.redirect;
    push_n     = !push ? CNT_W'(0) : (skip_low_q ? CNT_W'(1) : CNT_W'(2));
    pop_n      = !pop  ? CNT_W'(0) : (head_is32  ? CNT_W'(2) : CNT_W'(1));
  end

  assign bus.fetch_ready      = !reset && (count_q <= CNT_ROOM);
  assign bus.fetch_req_pc     = req_pc_q;
  assign bus.instr_valid      = have_instr;
  assign bus.instr            = head_is32 ? {next_hw, head_hw} : {16'h0, head_hw};
  assign bus.instr_pc         = pc_q;
  assign bus.instr_compressed = have_instr && !head_is32;
  assign bus.instr_illegal    = have_instr && !head_is32 && !ENABLE_C;
  assign bus.count            = count_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    skip_low_d = skip_low_q;
    if (bus.redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pc_d       = {bus.redirect_pc[31:1], 1'b0};
      req_pc_d   = {bus.redirect_pc[31:2], 2'b00};
      skip_low_d = bus.redirect_pc[1];
    end else begin
      count_d  = count_q + push_n - pop_n;
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      if (pop) begin
        pc_d = pc_q + (head_is32 ? 32'd4 : 32'd2);
      end
      if (push) begin
        req_pc_d   = req_pc_q + 32'd4;
        skip_low_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      req_pc_q   <= {RESET_PC[31:2], 2'b00};
      skip_low_q <= RESET_PC[1];
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      skip_low_q <= skip_low_d;
    end
  end

  // Buffer storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip_low_q) begin
        slot_q[wr_ptr_q] <= bus.fetch_word[31:16];
      end else begin
        slot_q[wr_ptr_q]             <= bus.fetch_word[15:0];
        slot_q[wr_ptr_q + PTR_W'(1)] <= bus.fetch_word[31:16];
      end
    end
  end
endmodule
